// File: rtl/instruction_loader.sv
// instruction_loader: packs a debug-UART byte stream into 32-bit instruction words and
// writes them to instruction memory at sequential word addresses, holding the pipeline
// stalled (out_load_busy) until the halt word is written or memory fills up.
// Optional feature macro: INSTR_CHECKSUM_EN (running XOR of written words, checked against
// a trailing 4-byte checksum word after the halt word; adds out_checksum).
module instruction_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_start,
    input  logic [7:0]        in_rx_data,
    input  logic              in_rx_valid,
    output logic              out_wr_instruction,
    output logic [31:0]       out_data_instruction,
    output logic [ADDR_W-1:0] out_wr_address,
    output logic              out_load_busy,
    output logic              out_load_done,
    output logic [ADDR_W:0]   out_word_count,
    output logic              out_error
`ifdef INSTR_CHECKSUM_EN
    ,
    output logic [31:0]       out_checksum
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RECV  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
`ifdef INSTR_CHECKSUM_EN
    localparam logic [2:0] CHECK = 3'd4;
`endif

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    logic [2:0]        stateQ, stateD;
    logic [1:0]        byteIdxQ, byteIdxD;
    logic [31:0]       asmQ, asmD;
    logic [31:0]       dataQ, dataD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [ADDR_W:0]   countQ, countD;
    logic              errorQ, errorD;
    logic [31:0]       shiftedWord;
`ifdef INSTR_CHECKSUM_EN
    logic [31:0]       xorQ, xorD;
`endif

    // Big-endian assembly: every new byte enters at the bottom, the first byte ends up in 31:24.
    assign shiftedWord = {asmQ[23:0], in_rx_data};

    // Next-state and datapath updates for the load session.
    always_comb begin
        stateD   = stateQ;
        byteIdxD = byteIdxQ;
        asmD     = asmQ;
        dataD    = dataQ;
        addrD    = addrQ;
        countD   = countQ;
        errorD   = errorQ;
`ifdef INSTR_CHECKSUM_EN
        xorD     = xorQ;
`endif
        case (stateQ)
            IDLE, DONE: begin
                // Incoming bytes are ignored here; only a start pulse opens a session.
                if (in_start) begin
                    stateD   = RECV;
                    byteIdxD = 2'd0;
                    asmD     = 32'd0;
                    addrD    = '0;
                    countD   = '0;
                    errorD   = 1'b0;
`ifdef INSTR_CHECKSUM_EN
                    xorD     = 32'd0;
`endif
                end
            end
            RECV: begin
                if (in_rx_valid) begin
                    asmD = shiftedWord;
                    if (byteIdxQ == 2'd3) begin
                        byteIdxD = 2'd0;
                        dataD    = shiftedWord;
                        stateD   = WRITE;
                    end else begin
                        byteIdxD = byteIdxQ + 2'd1;
                    end
                end
            end
            WRITE: begin
                countD = countQ + (ADDR_W + 1)'(1);
`ifdef INSTR_CHECKSUM_EN
                xorD   = xorQ ^ dataQ;
`endif
                // A byte arriving during the write strobe starts the next word.
                if (in_rx_valid) begin
                    asmD     = shiftedWord;
                    byteIdxD = 2'd1;
                end
                // Address saturates at the last slot so it never points outside memory.
                if (addrQ != LastAddr) begin
                    addrD = addrQ + ADDR_W'(1);
                end
                if (dataQ == HALT_WORD) begin
`ifdef INSTR_CHECKSUM_EN
                    stateD = CHECK;
`else
                    stateD = DONE;
`endif
                end else if (addrQ == LastAddr) begin
                    stateD = DONE;
                    errorD = 1'b1;
                end else begin
                    stateD = RECV;
                end
            end
`ifdef INSTR_CHECKSUM_EN
            CHECK: begin
                // The checksum word is compared only, never written to memory.
                if (in_rx_valid) begin
                    asmD = shiftedWord;
                    if (byteIdxQ == 2'd3) begin
                        byteIdxD = 2'd0;
                        stateD   = DONE;
                        if (shiftedWord != xorQ) begin
                            errorD = 1'b1;
                        end
                    end else begin
                        byteIdxD = byteIdxQ + 2'd1;
                    end
                end
            end
`endif
            default: stateD = IDLE;
        endcase
    end

    // State registers; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ   <= IDLE;
            byteIdxQ <= 2'd0;
            asmQ     <= 32'd0;
            dataQ    <= 32'd0;
            addrQ    <= '0;
            countQ   <= '0;
            errorQ   <= 1'b0;
`ifdef INSTR_CHECKSUM_EN
            xorQ     <= 32'd0;
`endif
        end else begin
            stateQ   <= stateD;
            byteIdxQ <= byteIdxD;
            asmQ     <= asmD;
            dataQ    <= dataD;
            addrQ    <= addrD;
            countQ   <= countD;
            errorQ   <= errorD;
`ifdef INSTR_CHECKSUM_EN
            xorQ     <= xorD;
`endif
        end
    end

    assign out_wr_instruction   = (stateQ == WRITE);
    assign out_data_instruction = dataQ;
    assign out_wr_address       = addrQ;
    assign out_load_done        = (stateQ == DONE);
    assign out_word_count       = countQ;
    assign out_error            = errorQ;
`ifdef INSTR_CHECKSUM_EN
    assign out_load_busy        = (stateQ == RECV) || (stateQ == WRITE) || (stateQ == CHECK);
    assign out_checksum         = xorQ;
`else
    assign out_load_busy        = (stateQ == RECV) || (stateQ == WRITE);
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a default-size instance (A) and a DEPTH=4
// instance (B) share the same stimulus; a negedge monitor logs every write strobe.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        inStart;
    logic [7:0]  inRxData;
    logic        inRxValid;

    logic        wrA, busyA, doneA, errA;
    logic [31:0] dataA;
    logic [7:0]  addrA;
    logic [8:0]  countA;
    logic        wrB, busyB, doneB, errB;
    logic [31:0] dataB;
    logic [1:0]  addrB;
    logic [2:0]  countB;
`ifdef INSTR_CHECKSUM_EN
    logic [31:0] chkA, chkB;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0] qDataA[$];
    logic [7:0]  qAddrA[$];
    logic [31:0] qDataB[$];
    logic [1:0]  qAddrB[$];

    always #5 clk = ~clk;

    instruction_loader dutA (
        .clk                  (clk),
        .rst                  (rst),
        .in_start             (inStart),
        .in_rx_data           (inRxData),
        .in_rx_valid          (inRxValid),
        .out_wr_instruction   (wrA),
        .out_data_instruction (dataA),
        .out_wr_address       (addrA),
        .out_load_busy        (busyA),
        .out_load_done        (doneA),
        .out_word_count       (countA),
        .out_error            (errA)
`ifdef INSTR_CHECKSUM_EN
        ,
        .out_checksum         (chkA)
`endif
    );

    instruction_loader #(.DEPTH(4), .ADDR_W(2)) dutB (
        .clk                  (clk),
        .rst                  (rst),
        .in_start             (inStart),
        .in_rx_data           (inRxData),
        .in_rx_valid          (inRxValid),
        .out_wr_instruction   (wrB),
        .out_data_instruction (dataB),
        .out_wr_address       (addrB),
        .out_load_busy        (busyB),
        .out_load_done        (doneB),
        .out_word_count       (countB),
        .out_error            (errB)
`ifdef INSTR_CHECKSUM_EN
        ,
        .out_checksum         (chkB)
`endif
    );

    // Log write strobes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (wrA === 1'b1) begin
            qDataA.push_back(dataA);
            qAddrA.push_back(addrA);
        end
        if (wrB === 1'b1) begin
            qDataB.push_back(dataB);
            qAddrB.push_back(addrB);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        inStart = 1'b0;
        inRxValid = 1'b0;
        inRxData = 8'h00;
        idle(2);
        rst = 1'b0;
        qDataA.delete();
        qAddrA.delete();
        qDataB.delete();
        qAddrB.delete();
    endtask

    task automatic pulseStart();
        inStart = 1'b1;
        idle(1);
        inStart = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        inRxData = b;
        inRxValid = 1'b1;
        idle(1);
        inRxValid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            sendByte(w[31 - 8 * i -: 8]);
        end
    endtask

    task automatic test_reset_and_first_word();
        doReset();
        testsRun++;
        if ({wrA, busyA, doneA, errA, dataA, addrA, countA} !== '0) begin
            testsFailed++;
            $display("FAIL reset_state: got wr=%b busy=%b done=%b err=%b data=%h addr=%h count=%0d, want all 0",
                     wrA, busyA, doneA, errA, dataA, addrA, countA);
        end
        pulseStart();
        testsRun++;
        if (busyA !== 1'b1) begin
            testsFailed++;
            $display("FAIL busy_after_start: got %b want 1", busyA);
        end
        sendByte(8'h20);
        sendByte(8'h01);
        sendByte(8'h00);
        sendByte(8'h05);
        testsRun++;
        if ({wrA, dataA, addrA} !== {1'b1, 32'h20010005, 8'd0}) begin
            testsFailed++;
            $display("FAIL first_write: got wr=%b data=%h addr=%h want wr=1 data=20010005 addr=00",
                     wrA, dataA, addrA);
        end
        idle(1);
        testsRun++;
        if ({wrA, busyA, countA} !== {1'b0, 1'b1, 9'd1}) begin
            testsFailed++;
            $display("FAIL after_first_write: got wr=%b busy=%b count=%0d want wr=0 busy=1 count=1",
                     wrA, busyA, countA);
        end
    endtask

    task automatic test_halt();
        doReset();
        pulseStart();
        sendWord(32'h00000001);
        sendWord(32'h00000002);
        sendWord(32'h00000004);
        sendWord(32'hFFFFFFFF);
`ifdef INSTR_CHECKSUM_EN
        sendWord(32'hFFFFFFF8);
`endif
        idle(2);
        testsRun++;
        if (qDataA.size() !== 4) begin
            testsFailed++;
            $display("FAIL halt_strobes: got %0d strobes want 4", qDataA.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                testsRun++;
                if (qAddrA[i] !== 8'(i)) begin
                    testsFailed++;
                    $display("FAIL halt_addr%0d: got %h want %h", i, qAddrA[i], 8'(i));
                end
            end
            testsRun++;
            if (qDataA[3] !== 32'hFFFFFFFF) begin
                testsFailed++;
                $display("FAIL halt_last_data: got %h want ffffffff", qDataA[3]);
            end
        end
        testsRun++;
        if ({doneA, busyA, countA, errA} !== {1'b1, 1'b0, 9'd4, 1'b0}) begin
            testsFailed++;
            $display("FAIL halt_status: got done=%b busy=%b count=%0d err=%b want 1 0 4 0",
                     doneA, busyA, countA, errA);
        end
    endtask

    task automatic test_overflow();
        doReset();
        pulseStart();
        for (int i = 0; i < 4; i++) begin
            sendWord(32'h10000000 + 32'(i));
        end
        idle(2);
        testsRun++;
        if (qDataB.size() !== 4) begin
            testsFailed++;
            $display("FAIL ovf_strobes: got %0d want 4", qDataB.size());
        end else begin
            testsRun++;
            if ({qAddrB[0], qAddrB[1], qAddrB[2], qAddrB[3]} !== {2'd0, 2'd1, 2'd2, 2'd3}) begin
                testsFailed++;
                $display("FAIL ovf_addrs: got %0d %0d %0d %0d want 0 1 2 3",
                         qAddrB[0], qAddrB[1], qAddrB[2], qAddrB[3]);
            end
        end
        testsRun++;
        if ({doneB, errB, countB, busyB} !== {1'b1, 1'b1, 3'd4, 1'b0}) begin
            testsFailed++;
            $display("FAIL ovf_status: got done=%b err=%b count=%0d busy=%b want 1 1 4 0",
                     doneB, errB, countB, busyB);
        end
        sendWord(32'h12345678);
        idle(2);
        testsRun++;
        if (qDataB.size() !== 4 || doneB !== 1'b1) begin
            testsFailed++;
            $display("FAIL ovf_ignored: got strobes=%0d done=%b want 4 1", qDataB.size(), doneB);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [8];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        doReset();
        pulseStart();
        inRxValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            inRxData = bytes[i];
            idle(1);
        end
        inRxValid = 1'b0;
        idle(2);
        testsRun++;
        if (qDataA.size() !== 2) begin
            testsFailed++;
            $display("FAIL b2b_strobes: got %0d want 2", qDataA.size());
        end else begin
            testsRun++;
            if ({qDataA[0], qDataA[1], qAddrA[1]} !== {32'h11223344, 32'h55667788, 8'd1}) begin
                testsFailed++;
                $display("FAIL b2b_words: got %h %h addr1=%h want 11223344 55667788 addr1=01",
                         qDataA[0], qDataA[1], qAddrA[1]);
            end
        end
        testsRun++;
        if (countA !== 9'd2) begin
            testsFailed++;
            $display("FAIL b2b_count: got %0d want 2", countA);
        end
    endtask

    task automatic test_mid_reset();
        doReset();
        pulseStart();
        sendByte(8'h20);
        sendByte(8'h01);
        rst = 1'b1;
        #2;
        testsRun++;
        if ({wrA, busyA, doneA, errA, dataA, addrA, countA} !== '0) begin
            testsFailed++;
            $display("FAIL midrst_outputs: got wr=%b busy=%b done=%b err=%b data=%h addr=%h count=%0d want 0",
                     wrA, busyA, doneA, errA, dataA, addrA, countA);
        end
        idle(1);
        rst = 1'b0;
        idle(1);
        testsRun++;
        if (qDataA.size() !== 0) begin
            testsFailed++;
            $display("FAIL midrst_no_strobe: got %0d strobes want 0", qDataA.size());
        end
        pulseStart();
        sendByte(8'hAA);
        sendByte(8'hBB);
        pulseStart();
        sendByte(8'hCC);
        sendByte(8'hDD);
        idle(1);
        testsRun++;
        if (qDataA.size() !== 1) begin
            testsFailed++;
            $display("FAIL midrst_restart_strobes: got %0d want 1", qDataA.size());
        end else begin
            testsRun++;
            if ({qDataA[0], qAddrA[0]} !== {32'hAABBCCDD, 8'd0}) begin
                testsFailed++;
                $display("FAIL midrst_restart_word: got %h @%h want aabbccdd @00",
                         qDataA[0], qAddrA[0]);
            end
        end
    endtask

`ifdef INSTR_CHECKSUM_EN
    task automatic test_checksum();
        doReset();
        pulseStart();
        sendWord(32'h0000000F);
        sendWord(32'hFFFFFFFF);
        idle(1);
        testsRun++;
        if ({busyA, doneA} !== 2'b10) begin
            testsFailed++;
            $display("FAIL chk_waiting: got busy=%b done=%b want 1 0", busyA, doneA);
        end
        sendWord(32'hFFFFFFF0);
        idle(1);
        testsRun++;
        if ({doneA, errA, chkA} !== {1'b1, 1'b0, 32'hFFFFFFF0}) begin
            testsFailed++;
            $display("FAIL chk_good: got done=%b err=%b chk=%h want 1 0 fffffff0", doneA, errA, chkA);
        end
        pulseStart();
        testsRun++;
        if (chkA !== 32'd0) begin
            testsFailed++;
            $display("FAIL chk_cleared: got %h want 0", chkA);
        end
        sendWord(32'h0000000F);
        sendWord(32'hFFFFFFFF);
        sendWord(32'h00000000);
        idle(1);
        testsRun++;
        if ({doneA, errA} !== 2'b11) begin
            testsFailed++;
            $display("FAIL chk_bad: got done=%b err=%b want 1 1", doneA, errA);
        end
        testsRun++;
        if (qDataA.size() !== 4 || qDataA[qDataA.size() - 1] !== 32'hFFFFFFFF) begin
            testsFailed++;
            $display("FAIL chk_not_written: got %0d strobes want 4 ending in ffffffff", qDataA.size());
        end
    endtask
`endif

    initial begin
        test_reset_and_first_word();
        test_halt();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
`ifdef INSTR_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
